// File: rtl/avr_lsu.sv
// avr_lsu - load/store and stack sequencer for the AVR core.
//
// Accepts one decoded memory request at a time (LD/ST through a pointer,
// PUSH/POP, CALL return-address push, RET return-address pop) and runs it
// as a byte-serial access sequence on a ready-handshaked data memory port.
// Owns the stack pointer and produces pointer write-back values.
//
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   req_valid/req_ready   request handshake (ready only in IDLE without sp_we)
//   req_op/mode/ptr/disp  decoded operation and addressing inputs
//   req_wdata, req_pc     store/push byte, return address for CALLPUSH
//   done, done_rdata,     one-cycle completion pulse with LD/POP byte and
//   done_pc               RETPOP return address
//   ptr_wb_valid, ptr_wb  pointer write-back for post-inc / pre-dec modes
//   sp, sp_we, sp_wdata   stack pointer and its direct load (IDLE only)
//   mem_*                 registered data-memory request, mem_ready completes
module avr_lsu #(
    parameter int          ADDR_WIDTH = 16,
    parameter int          PC_BYTES   = 2,
    parameter int unsigned SP_RESET   = 16'h08FF
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic [2:0]              req_op,
    input  logic [1:0]              req_mode,
    input  logic [ADDR_WIDTH-1:0]   req_ptr,
    input  logic [5:0]              req_disp,
    input  logic [7:0]              req_wdata,
    input  logic [8*PC_BYTES-1:0]   req_pc,
    output logic                    done,
    output logic [7:0]              done_rdata,
    output logic [8*PC_BYTES-1:0]   done_pc,
    output logic                    ptr_wb_valid,
    output logic [ADDR_WIDTH-1:0]   ptr_wb,
    output logic [ADDR_WIDTH-1:0]   sp,
    input  logic                    sp_we,
    input  logic [ADDR_WIDTH-1:0]   sp_wdata,
    output logic [ADDR_WIDTH-1:0]   mem_addr,
    output logic                    mem_en,
    output logic                    mem_wen,
    output logic [7:0]              mem_wdata,
    input  logic                    mem_ready,
    input  logic [7:0]              mem_rdata
);
    localparam int PCW = 8 * PC_BYTES;
    localparam int CW  = $clog2(PC_BYTES + 1);
    localparam logic [ADDR_WIDTH-1:0] SP_INIT = ADDR_WIDTH'(SP_RESET);

    localparam logic [2:0] OP_LD       = 3'd0;
    localparam logic [2:0] OP_ST       = 3'd1;
    localparam logic [2:0] OP_PUSH     = 3'd2;
    localparam logic [2:0] OP_POP      = 3'd3;
    localparam logic [2:0] OP_CALLPUSH = 3'd4;
    localparam logic [2:0] OP_RETPOP   = 3'd5;

    typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_DONE} state_t;

    state_t                  state_q;
    logic [CW-1:0]           cnt_q;
    logic                    push_q;    // stack grows down: address and SP decrement
    logic                    pop_q;     // stack shrinks: SP increments
    logic                    wbv_q;
    logic [PCW-1:0]          pc_q;      // remaining CALLPUSH bytes, next byte in [7:0]
    logic [ADDR_WIDTH-1:0]   sp_q;
    logic [ADDR_WIDTH-1:0]   mem_addr_q;
    logic                    mem_en_q, mem_wen_q;
    logic [7:0]              mem_wdata_q;
    logic                    done_q, ptr_wb_valid_q;
    logic [7:0]              done_rdata_q;
    logic [PCW-1:0]          done_pc_q;
    logic [ADDR_WIDTH-1:0]   ptr_wb_q;

    // Request decode, evaluated against the live request and SP in IDLE.
    logic [ADDR_WIDTH-1:0]   addr_d, ptr_wb_d;
    logic                    wbv_d, wen_d;
    logic [7:0]              wdata_d;
    logic [CW-1:0]           n_d;
    logic                    rsvd;

    assign rsvd = (req_op > OP_RETPOP);

    always_comb begin
        addr_d   = req_ptr;
        ptr_wb_d = req_ptr;
        wbv_d    = 1'b0;
        wen_d    = 1'b0;
        wdata_d  = req_wdata;
        n_d      = CW'(1);
        case (req_op)
            OP_LD, OP_ST: begin
                wen_d = (req_op == OP_ST);
                case (req_mode)
                    2'd1: begin
                        ptr_wb_d = req_ptr + ADDR_WIDTH'(1);
                        wbv_d    = 1'b1;
                    end
                    2'd2: begin
                        addr_d   = req_ptr - ADDR_WIDTH'(1);
                        ptr_wb_d = req_ptr - ADDR_WIDTH'(1);
                        wbv_d    = 1'b1;
                    end
                    2'd3:    addr_d = req_ptr + ADDR_WIDTH'(req_disp);
                    default: ;
                endcase
            end
            OP_PUSH: begin
                addr_d = sp_q;
                wen_d  = 1'b1;
            end
            OP_POP:  addr_d = sp_q + ADDR_WIDTH'(1);
            OP_CALLPUSH: begin
                addr_d  = sp_q;
                wen_d   = 1'b1;
                wdata_d = req_pc[7:0];
                n_d     = CW'(PC_BYTES);
            end
            OP_RETPOP: begin
                addr_d = sp_q + ADDR_WIDTH'(1);
                n_d    = CW'(PC_BYTES);
            end
            default: ;
        endcase
    end

    assign req_ready = (state_q == S_IDLE) && !sp_we;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= S_IDLE;
            cnt_q          <= '0;
            push_q         <= 1'b0;
            pop_q          <= 1'b0;
            wbv_q          <= 1'b0;
            pc_q           <= '0;
            sp_q           <= SP_INIT;
            mem_addr_q     <= '0;
            mem_en_q       <= 1'b0;
            mem_wen_q      <= 1'b0;
            mem_wdata_q    <= '0;
            done_q         <= 1'b0;
            ptr_wb_valid_q <= 1'b0;
            done_rdata_q   <= '0;
            done_pc_q      <= '0;
            ptr_wb_q       <= '0;
        end else begin
            done_q         <= 1'b0;
            ptr_wb_valid_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (sp_we) begin
                        sp_q <= sp_wdata;
                    end else if (req_valid) begin
                        cnt_q    <= n_d;
                        push_q   <= (req_op == OP_PUSH) || (req_op == OP_CALLPUSH);
                        pop_q    <= (req_op == OP_POP)  || (req_op == OP_RETPOP);
                        wbv_q    <= wbv_d;
                        ptr_wb_q <= ptr_wb_d;
                        pc_q     <= req_pc >> 8;
                        if (rsvd) begin
                            // Reserved ops complete immediately with no access.
                            state_q      <= S_DONE;
                            done_q       <= 1'b1;
                            done_rdata_q <= '0;
                        end else begin
                            state_q     <= S_ACCESS;
                            mem_en_q    <= 1'b1;
                            mem_addr_q  <= addr_d;
                            mem_wen_q   <= wen_d;
                            mem_wdata_q <= wdata_d;
                        end
                    end
                end
                S_ACCESS: begin
                    // Nothing moves while mem_ready is low, so a stall holds
                    // address, data and SP exactly.
                    if (mem_ready) begin
                        if (push_q) begin
                            mem_addr_q <= mem_addr_q - ADDR_WIDTH'(1);
                            sp_q       <= sp_q - ADDR_WIDTH'(1);
                        end else begin
                            mem_addr_q <= mem_addr_q + ADDR_WIDTH'(1);
                        end
                        if (pop_q) sp_q <= sp_q + ADDR_WIDTH'(1);
                        mem_wdata_q  <= pc_q[7:0];
                        pc_q         <= pc_q >> 8;
                        done_rdata_q <= mem_rdata;
                        // RETPOP reads MSB first, so shift bytes in from the bottom.
                        done_pc_q    <= {done_pc_q[PCW-9:0], mem_rdata};
                        cnt_q        <= cnt_q - CW'(1);
                        if (cnt_q == CW'(1)) begin
                            mem_en_q       <= 1'b0;
                            state_q        <= S_DONE;
                            done_q         <= 1'b1;
                            ptr_wb_valid_q <= wbv_q;
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign done         = done_q;
    assign done_rdata   = done_rdata_q;
    assign done_pc      = done_pc_q;
    assign ptr_wb_valid = ptr_wb_valid_q;
    assign ptr_wb       = ptr_wb_q;
    assign sp           = sp_q;
    assign mem_addr     = mem_addr_q;
    assign mem_en       = mem_en_q;
    assign mem_wen      = mem_wen_q;
    assign mem_wdata    = mem_wdata_q;
endmodule

// File: tb/tb_avr_lsu.sv
module tb_avr_lsu;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        req_valid2, req_valid3;
    logic [2:0]  req_op;
    logic [1:0]  req_mode;
    logic [15:0] req_ptr;
    logic [5:0]  req_disp;
    logic [7:0]  req_wdata;
    logic [23:0] req_pc;
    logic        sp_we;
    logic [15:0] sp_wdata;
    logic        mem_ready;

    logic        req_ready2, done2, ptr_wb_valid2, mem_en2, mem_wen2;
    logic [7:0]  done_rdata2, mem_wdata2, mem_rdata2;
    logic [15:0] done_pc2, ptr_wb2, sp2, mem_addr2;
    logic        req_ready3, done3, ptr_wb_valid3, mem_en3, mem_wen3;
    logic [7:0]  done_rdata3, mem_wdata3, mem_rdata3;
    logic [23:0] done_pc3;
    logic [15:0] ptr_wb3, sp3, mem_addr3;

    logic [7:0]  mem2 [0:65535];
    assign mem_rdata2 = mem2[mem_addr2];
    assign mem_rdata3 = 8'h00;

    avr_lsu #(.ADDR_WIDTH(16), .PC_BYTES(2), .SP_RESET(16'h08FF)) u2 (
        .clk(clk), .reset(reset), .req_valid(req_valid2), .req_ready(req_ready2),
        .req_op(req_op), .req_mode(req_mode), .req_ptr(req_ptr), .req_disp(req_disp),
        .req_wdata(req_wdata), .req_pc(req_pc[15:0]), .done(done2), .done_rdata(done_rdata2),
        .done_pc(done_pc2), .ptr_wb_valid(ptr_wb_valid2), .ptr_wb(ptr_wb2), .sp(sp2),
        .sp_we(sp_we), .sp_wdata(sp_wdata), .mem_addr(mem_addr2), .mem_en(mem_en2),
        .mem_wen(mem_wen2), .mem_wdata(mem_wdata2), .mem_ready(mem_ready), .mem_rdata(mem_rdata2));

    avr_lsu #(.ADDR_WIDTH(16), .PC_BYTES(3), .SP_RESET(16'h08FF)) u3 (
        .clk(clk), .reset(reset), .req_valid(req_valid3), .req_ready(req_ready3),
        .req_op(req_op), .req_mode(req_mode), .req_ptr(req_ptr), .req_disp(req_disp),
        .req_wdata(req_wdata), .req_pc(req_pc), .done(done3), .done_rdata(done_rdata3),
        .done_pc(done_pc3), .ptr_wb_valid(ptr_wb_valid3), .ptr_wb(ptr_wb3), .sp(sp3),
        .sp_we(sp_we), .sp_wdata(sp_wdata), .mem_addr(mem_addr3), .mem_en(mem_en3),
        .mem_wen(mem_wen3), .mem_wdata(mem_wdata3), .mem_ready(mem_ready), .mem_rdata(mem_rdata3));

    typedef struct { logic [15:0] addr; logic wen; logic [7:0] wdata; } acc_t;
    typedef struct {
        int acc; int dcyc; logic chk_rd; logic [7:0] rdata; logic chk_pc; logic [15:0] pc;
        logic wbv; logic [15:0] wb; logic [15:0] sp;
    } res_t;
    typedef struct {
        logic [2:0] op; logic [1:0] mode; logic [15:0] ptr; logic [5:0] disp; logic [7:0] wdata;
        logic pl; logic [7:0] pl_data; logic [15:0] addr; logic [7:0] rdata; logic wbv; logic [15:0] wb;
    } vec_t;

    acc_t exp_acc2[$];
    acc_t exp_acc3[$];
    res_t sb2[$];
    vec_t vecs[8];

    int   errors = 0, checks = 0, cyc = 0, acc_cyc = 0;
    int   done_cnt2 = 0, done_cnt3 = 0, stall_cnt = 0;
    logic rdy2_s, rdy3_s, stl_prev = 1'b0;
    acc_t stl_hold;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_acc(input string tag, input logic [15:0] a, input logic w,
                           input logic [7:0] d, inout acc_t q[$]);
        acc_t e;
        if (q.size() == 0) begin
            checks++; errors++;
            $display("FAIL %s unexpected access: addr %0h", tag, a);
        end else begin
            e = q.pop_front();
            chk({tag, " addr"}, 32'(a), 32'(e.addr));
            chk({tag, " wen"}, 32'(w), 32'(e.wen));
            if (e.wen) chk({tag, " wdata"}, 32'(d), 32'(e.wdata));
        end
    endtask

    // One clock: sample and score at the falling edge, then return 1 after the rising edge.
    task automatic step();
        res_t r;
        @(negedge clk);
        rdy2_s = req_ready2;
        rdy3_s = req_ready3;
        if (!reset) begin
            if (mem_en2) begin
                if (stl_prev) begin
                    chk("stall addr", 32'(mem_addr2), 32'(stl_hold.addr));
                    chk("stall wen", 32'(mem_wen2), 32'(stl_hold.wen));
                    chk("stall wdata", 32'(mem_wdata2), 32'(stl_hold.wdata));
                end
                stl_prev = !mem_ready;
                stl_hold = '{mem_addr2, mem_wen2, mem_wdata2};
                if (mem_ready) begin
                    chk_acc("acc2", mem_addr2, mem_wen2, mem_wdata2, exp_acc2);
                    if (mem_wen2) mem2[mem_addr2] = mem_wdata2;
                end else stall_cnt++;
            end else begin
                if (stl_prev) chk("stall mem_en", 32'(mem_en2), 32'd1);
                stl_prev = 1'b0;
            end
            if (mem_en3 && mem_ready) chk_acc("acc3", mem_addr3, mem_wen3, mem_wdata3, exp_acc3);
            if (done2) begin
                done_cnt2++;
                if (sb2.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL done2 unexpected pulse at cycle %0d", cyc);
                end else begin
                    r = sb2.pop_front();
                    chk("done cycle", 32'(cyc - r.acc + 1), 32'(r.dcyc));
                    if (r.chk_rd) chk("done_rdata", 32'(done_rdata2), 32'(r.rdata));
                    if (r.chk_pc) chk("done_pc", 32'(done_pc2), 32'(r.pc));
                    chk("ptr_wb_valid", 32'(ptr_wb_valid2), 32'(r.wbv));
                    if (r.wbv) chk("ptr_wb", 32'(ptr_wb2), 32'(r.wb));
                    chk("sp at done", 32'(sp2), 32'(r.sp));
                end
            end
            if (done3) done_cnt3++;
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic issue(input int inst, input logic [2:0] op, input logic [1:0] mode,
                         input logic [15:0] ptr, input logic [5:0] disp,
                         input logic [7:0] wdata, input logic [23:0] pc);
        logic ok;
        ok = 1'b0;
        req_op = op; req_mode = mode; req_ptr = ptr; req_disp = disp;
        req_wdata = wdata; req_pc = pc;
        if (inst == 0) req_valid2 = 1'b1; else req_valid3 = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step();
            if ((inst == 0) ? rdy2_s : rdy3_s) begin ok = 1'b1; break; end
        end
        req_valid2 = 1'b0;
        req_valid3 = 1'b0;
        acc_cyc = cyc;
        if (!ok) begin
            checks++; errors++;
            $display("FAIL accept timeout: op %0d inst %0d", op, inst);
        end
    endtask

    task automatic wait_done(input int inst);
        int s;
        logic seen;
        seen = 1'b0;
        s = (inst == 0) ? done_cnt2 : done_cnt3;
        for (int i = 0; i < 60; i++) begin
            step();
            if (((inst == 0) ? done_cnt2 : done_cnt3) != s) begin seen = 1'b1; break; end
        end
        chk("done seen", 32'(seen), 32'd1);
    endtask

    initial begin
        int c0, d0, s0;
        reset = 1'b1; req_valid2 = 1'b0; req_valid3 = 1'b0; req_op = '0; req_mode = '0;
        req_ptr = '0; req_disp = '0; req_wdata = '0; req_pc = '0; sp_we = 1'b0;
        sp_wdata = '0; mem_ready = 1'b1;

        //            op    md  ptr       dsp    wdata  pl  pl_d   addr      rdata  wbv wb
        vecs[0] = '{3'd0, 2'd1, 16'h0100, 6'h00, 8'h00, 1, 8'h5A, 16'h0100, 8'h5A, 1, 16'h0101};
        vecs[1] = '{3'd0, 2'd0, 16'h1234, 6'h00, 8'h00, 1, 8'h77, 16'h1234, 8'h77, 0, 16'h0000};
        vecs[2] = '{3'd0, 2'd2, 16'h0000, 6'h00, 8'h00, 1, 8'h3C, 16'hFFFF, 8'h3C, 1, 16'hFFFF};
        vecs[3] = '{3'd0, 2'd3, 16'hFFF0, 6'h3F, 8'h00, 1, 8'h96, 16'h002F, 8'h96, 0, 16'h0000};
        vecs[4] = '{3'd1, 2'd1, 16'hFFFF, 6'h00, 8'hA1, 0, 8'h00, 16'hFFFF, 8'h00, 1, 16'h0000};
        vecs[5] = '{3'd1, 2'd3, 16'h0300, 6'h05, 8'h42, 0, 8'h00, 16'h0305, 8'h00, 0, 16'h0000};
        vecs[6] = '{3'd0, 2'd3, 16'h0305, 6'h00, 8'h00, 0, 8'h00, 16'h0305, 8'h42, 0, 16'h0000};
        vecs[7] = '{3'd1, 2'd0, 16'h0400, 6'h00, 8'h11, 0, 8'h00, 16'h0400, 8'h00, 0, 16'h0000};

        // Reset values
        step(); step();
        chk("rst mem_en", 32'(mem_en2), 32'd0);
        chk("rst mem_wen", 32'(mem_wen2), 32'd0);
        chk("rst mem_addr", 32'(mem_addr2), 32'd0);
        chk("rst mem_wdata", 32'(mem_wdata2), 32'd0);
        chk("rst sp2", 32'(sp2), 32'h08FF);
        chk("rst sp3", 32'(sp3), 32'h08FF);
        chk("rst done", 32'(done2), 32'd0);
        chk("rst ptr_wb_valid", 32'(ptr_wb_valid2), 32'd0);
        chk("rst ptr_wb", 32'(ptr_wb2), 32'd0);
        chk("rst done_rdata", 32'(done_rdata2), 32'd0);
        chk("rst done_pc", 32'(done_pc2), 32'd0);
        reset = 1'b0;
        chk("rst req_ready", 32'(req_ready2), 32'd1);

        // LD/ST addressing table
        foreach (vecs[i]) begin
            if (vecs[i].pl) mem2[vecs[i].addr] = vecs[i].pl_data;
            exp_acc2.push_back('{vecs[i].addr, vecs[i].op == 3'd1, vecs[i].wdata});
            issue(0, vecs[i].op, vecs[i].mode, vecs[i].ptr, vecs[i].disp, vecs[i].wdata, 24'h0);
            sb2.push_back('{acc_cyc, 2, vecs[i].op == 3'd0, vecs[i].rdata, 1'b0, 16'h0,
                            vecs[i].wbv, vecs[i].wb, 16'h08FF});
            wait_done(0);
        end

        // ST pre-dec with three wait states
        mem_ready = 1'b0;
        s0 = stall_cnt;
        exp_acc2.push_back('{16'h01FF, 1'b1, 8'hC3});
        issue(0, 3'd1, 2'd2, 16'h0200, 6'h00, 8'hC3, 24'h0);
        sb2.push_back('{acc_cyc, 5, 1'b0, 8'h00, 1'b0, 16'h0, 1'b1, 16'h01FF, 16'h08FF});
        step(); step(); step();
        mem_ready = 1'b1;
        wait_done(0);
        chk("stall cycles", 32'(stall_cnt - s0), 32'd3);

        // PUSH then POP
        exp_acc2.push_back('{16'h08FF, 1'b1, 8'hE7});
        issue(0, 3'd2, 2'd0, 16'h0, 6'h0, 8'hE7, 24'h0);
        sb2.push_back('{acc_cyc, 2, 1'b0, 8'h00, 1'b0, 16'h0, 1'b0, 16'h0, 16'h08FE});
        wait_done(0);
        exp_acc2.push_back('{16'h08FF, 1'b0, 8'h00});
        issue(0, 3'd3, 2'd0, 16'h0, 6'h0, 8'h00, 24'h0);
        sb2.push_back('{acc_cyc, 2, 1'b1, 8'hE7, 1'b0, 16'h0, 1'b0, 16'h0, 16'h08FF});
        wait_done(0);

        // CALLPUSH / RETPOP round trip
        exp_acc2.push_back('{16'h08FF, 1'b1, 8'h34});
        exp_acc2.push_back('{16'h08FE, 1'b1, 8'h12});
        issue(0, 3'd4, 2'd0, 16'h0, 6'h0, 8'h00, 24'h001234);
        sb2.push_back('{acc_cyc, 3, 1'b0, 8'h00, 1'b0, 16'h0, 1'b0, 16'h0, 16'h08FD});
        wait_done(0);
        exp_acc2.push_back('{16'h08FE, 1'b0, 8'h00});
        exp_acc2.push_back('{16'h08FF, 1'b0, 8'h00});
        issue(0, 3'd5, 2'd0, 16'h0, 6'h0, 8'h00, 24'h0);
        sb2.push_back('{acc_cyc, 3, 1'b0, 8'h00, 1'b1, 16'h1234, 1'b0, 16'h0, 16'h08FF});
        wait_done(0);

        // Reserved op: no access, done in cycle 1, zero data
        issue(0, 3'd7, 2'd1, 16'h0100, 6'h0, 8'h00, 24'h0);
        sb2.push_back('{acc_cyc, 1, 1'b1, 8'h00, 1'b0, 16'h0, 1'b0, 16'h0, 16'h08FF});
        wait_done(0);

        // sp_we together with a request
        sp_we = 1'b1; sp_wdata = 16'h0500;
        req_op = 3'd2; req_wdata = 8'h99; req_valid2 = 1'b1;
        step();
        c0 = cyc;
        chk("ready during sp_we", 32'(rdy2_s), 32'd0);
        sp_we = 1'b0;
        chk("sp loaded", 32'(sp2), 32'h0500);
        exp_acc2.push_back('{16'h0500, 1'b1, 8'h99});
        issue(0, 3'd2, 2'd0, 16'h0, 6'h0, 8'h99, 24'h0);
        chk("accept after sp_we", 32'(acc_cyc - c0), 32'd1);
        sb2.push_back('{acc_cyc, 2, 1'b0, 8'h00, 1'b0, 16'h0, 1'b0, 16'h0, 16'h04FF});
        wait_done(0);
        chk("sb2 drained", 32'(sb2.size()), 32'd0);
        chk("acc2 drained", 32'(exp_acc2.size()), 32'd0);

        // PC_BYTES=3 CALLPUSH wrapping below address 0
        sp_we = 1'b1; sp_wdata = 16'h0001;
        step();
        sp_we = 1'b0;
        chk("sp3 loaded", 32'(sp3), 32'h0001);
        exp_acc3.push_back('{16'h0001, 1'b1, 8'hDE});
        exp_acc3.push_back('{16'h0000, 1'b1, 8'hBC});
        exp_acc3.push_back('{16'hFFFF, 1'b1, 8'h3A});
        issue(1, 3'd4, 2'd0, 16'h0, 6'h0, 8'h00, 24'h3ABCDE);
        c0 = acc_cyc;
        wait_done(1);
        chk("u3 done cycle", 32'(cyc - c0), 32'd4);
        chk("u3 sp wrap", 32'(sp3), 32'hFFFE);
        chk("acc3 drained", 32'(exp_acc3.size()), 32'd0);

        // Reset during the second byte of a RETPOP (u2 SP is 0x0001 now)
        exp_acc2.push_back('{16'h0002, 1'b0, 8'h00});
        exp_acc2.push_back('{16'h0003, 1'b0, 8'h00});
        issue(0, 3'd5, 2'd0, 16'h0, 6'h0, 8'h00, 24'h0);
        d0 = done_cnt2;
        step();
        chk("retpop byte1 seen", 32'(exp_acc2.size()), 32'd1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        exp_acc2.delete();
        chk("mid-rst mem_en", 32'(mem_en2), 32'd0);
        chk("mid-rst sp", 32'(sp2), 32'h08FF);
        chk("mid-rst done", 32'(done2), 32'd0);
        chk("mid-rst req_ready", 32'(req_ready2), 32'd1);
        repeat (4) step();
        chk("no done after rst", 32'(done_cnt2 - d0), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
